video_pkt_ctrl: RTL and testbench

VIDEO_PKT_CTRL -- requirements
Module: video_pkt_ctrl

---
 rtl/video_pkt_ctrl.sv | 166 ++++++++++++++++
 tb/tb_video_pkt_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// VideoPktCtrl : sequences one UDP packet at a time from a video read FIFO.
// Each packet is a 4-byte header (frame number, packet number, MSB first)
// followed by PKT_PAYLOAD bytes pulled from the FIFO on the transmitter's
// byte requests. Frame and packet numbers advance when the transmitter
// reports the packet as sent.
//
// Ports
//   video_rd_clk   in   sole clock, rising edge
//   Reset          in   asynchronous active-high reset
//   ctrl_en        in   level enable for starting new packets
//   video_rd_rdy   in   FIFO holds at least one packet of data
//   video_rd_en    out  FIFO read strobe (data valid one cycle later)
//   video_rd_data  in   FIFO read data
//   tx_start_en    out  one-cycle transmit request
//   tx_byte_num    out  UDP payload length (PKT_PAYLOAD + 4)
//   tx_req         in   transmitter byte request (byte due next cycle)
//   tx_data        out  byte to transmitter
//   tx_done        in   packet fully sent
//   frame_cnt      out  current frame number
//   pkt_cnt        out  current packet index within frame
//   err_overrun    out  sticky: tx_req seen outside HDR/PAYLOAD
// ---------------------------------------------------------------------------
module video_pkt_ctrl #(
    parameter int PKT_PAYLOAD    = 1024,
    parameter int PKTS_PER_FRAME = 4050
) (
    input  logic        video_rd_clk,
    input  logic        Reset,
    input  logic        ctrl_en,
    input  logic        video_rd_rdy,
    output logic        video_rd_en,
    input  logic [7:0]  video_rd_data,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    input  logic        tx_req,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic [15:0] frame_cnt,
    output logic [15:0] pkt_cnt,
    output logic        err_overrun
);

    typedef enum logic [2:0] {IDLE, START, HDR, PAYLOAD, WAIT_DONE} state_t;

    localparam logic [15:0] LP_BYTE_NUM = 16'(PKT_PAYLOAD + 4);
    localparam logic [15:0] LP_PAY_LAST = 16'(PKT_PAYLOAD - 1);
    localparam logic [15:0] LP_PKT_LAST = 16'(PKTS_PER_FRAME - 1);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_hdr_cnt;
    logic [15:0] r_pay_cnt;
    logic [15:0] r_frame_cnt;
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_hdr_frame;
    logic [15:0] r_hdr_pkt;
    logic [7:0]  r_hdr_byte;
    logic        r_sel_fifo;
    logic        r_err;
    logic [7:0]  w_hdr_sel;

    // State register.
    always_ff @(posedge video_rd_clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. Only IDLE looks at ctrl_en/video_rd_rdy, so a packet
    // in flight always runs to completion regardless of those inputs.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (ctrl_en && video_rd_rdy) w_next = START;
            START:     w_next = HDR;
            HDR:       if (tx_req && (r_hdr_cnt == 2'd3)) w_next = PAYLOAD;
            PAYLOAD:   if (tx_req && (r_pay_cnt == LP_PAY_LAST)) w_next = WAIT_DONE;
            WAIT_DONE: if (tx_done) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Outputs. tx_data source is chosen by a flag registered with the
    // request, so the final payload byte still comes from the FIFO in the
    // first WAIT_DONE cycle.
    always_comb begin
        tx_start_en = (r_state == START);
        video_rd_en = (r_state == PAYLOAD) && tx_req;
        tx_byte_num = (r_state == IDLE) ? 16'd0 : LP_BYTE_NUM;
        tx_data     = r_sel_fifo ? video_rd_data : r_hdr_byte;
    end

    // Header byte selection from the counters snapshotted at START.
    always_comb begin
        w_hdr_sel = 8'd0;
        case (r_hdr_cnt)
            2'd0: w_hdr_sel = r_hdr_frame[15:8];
            2'd1: w_hdr_sel = r_hdr_frame[7:0];
            2'd2: w_hdr_sel = r_hdr_pkt[15:8];
            2'd3: w_hdr_sel = r_hdr_pkt[7:0];
            default: w_hdr_sel = 8'd0;
        endcase
    end

    // Datapath: byte counters, header/select registers, frame/packet
    // numbering and the sticky overrun flag. The header byte register falls
    // back to 0 on any cycle without a header request.
    always_ff @(posedge video_rd_clk or posedge Reset) begin
        if (Reset) begin
            r_hdr_cnt   <= 2'd0;
            r_pay_cnt   <= 16'd0;
            r_frame_cnt <= 16'd0;
            r_pkt_cnt   <= 16'd0;
            r_hdr_frame <= 16'd0;
            r_hdr_pkt   <= 16'd0;
            r_hdr_byte  <= 8'd0;
            r_sel_fifo  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_hdr_byte <= 8'd0;
            r_sel_fifo <= 1'b0;
            case (r_state)
                START: begin
                    r_hdr_cnt   <= 2'd0;
                    r_pay_cnt   <= 16'd0;
                    r_hdr_frame <= r_frame_cnt;
                    r_hdr_pkt   <= r_pkt_cnt;
                end
                HDR: begin
                    if (tx_req) begin
                        r_hdr_cnt  <= r_hdr_cnt + 2'd1;
                        r_hdr_byte <= w_hdr_sel;
                    end
                end
                PAYLOAD: begin
                    if (tx_req) begin
                        r_pay_cnt  <= r_pay_cnt + 16'd1;
                        r_sel_fifo <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        if (r_pkt_cnt == LP_PKT_LAST) begin
                            r_pkt_cnt   <= 16'd0;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end else begin
                            r_pkt_cnt <= r_pkt_cnt + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
            if (tx_req && ((r_state == IDLE) || (r_state == START) || (r_state == WAIT_DONE))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign frame_cnt   = r_frame_cnt;
    assign pkt_cnt     = r_pkt_cnt;
    assign err_overrun = r_err;

endmodule

// File: tb/tb_video_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for video_pkt_ctrl with PKT_PAYLOAD=8, PKTS_PER_FRAME=3.
// A packet-level model tracks frame/packet numbering and builds the byte
// stream each packet must produce (4 header bytes + random FIFO bytes).
// Inputs are driven on the falling edge, outputs sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_video_pkt_ctrl;

    localparam int PAY = 8;
    localparam int PPF = 3;
    localparam int NBYTES = PAY + 4;

    logic        video_rd_clk;
    logic        Reset;
    logic        ctrl_en;
    logic        video_rd_rdy;
    logic        video_rd_en;
    logic [7:0]  video_rd_data;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [15:0] frame_cnt;
    logic [15:0] pkt_cnt;
    logic        err_overrun;

    int total = 0;
    int bad = 0;
    int rdEnCount = 0;
    int startCount = 0;
    int expFrame = 0;
    int expPkt = 0;
    logic [7:0] expStream [NBYTES];

    video_pkt_ctrl #(.PKT_PAYLOAD(PAY), .PKTS_PER_FRAME(PPF)) dut (
        .video_rd_clk (video_rd_clk),
        .Reset        (Reset),
        .ctrl_en      (ctrl_en),
        .video_rd_rdy (video_rd_rdy),
        .video_rd_en  (video_rd_en),
        .video_rd_data(video_rd_data),
        .tx_start_en  (tx_start_en),
        .tx_byte_num  (tx_byte_num),
        .tx_req       (tx_req),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
        .frame_cnt    (frame_cnt),
        .pkt_cnt      (pkt_cnt),
        .err_overrun  (err_overrun)
    );

    initial video_rd_clk = 1'b0;
    always #5 video_rd_clk = ~video_rd_clk;

    // Count strobes as the DUT's clock edge sees them.
    always @(posedge video_rd_clk) begin
        if (video_rd_en === 1'b1) rdEnCount++;
        if (tx_start_en === 1'b1) startCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packet numbering rule applied when a packet is reported as sent.
    task automatic modelDone();
        if (expPkt == PPF - 1) begin
            expPkt = 0;
            expFrame = (expFrame + 1) % 65536;
        end else begin
            expPkt = expPkt + 1;
        end
    endtask

    task automatic buildStream();
        expStream[0] = 8'(expFrame / 256);
        expStream[1] = 8'(expFrame % 256);
        expStream[2] = 8'(expPkt / 256);
        expStream[3] = 8'(expPkt % 256);
        for (int k = 4; k < NBYTES; k++) expStream[k] = 8'($urandom);
    endtask

    task automatic waitStart();
        bit found;
        found = 1'b0;
        for (int c = 0; c < 150 && !found; c++) begin
            @(negedge video_rd_clk);
            #1;
            if (tx_start_en === 1'b1) found = 1'b1;
        end
        checkOutput("startSeen", 32'(found), 32'd1);
        checkOutput("byteNumStart", 32'(tx_byte_num), 32'(NBYTES));
    endtask

    // Issues the first nBytes requests of the stream with the chosen gap
    // pattern (0: back-to-back, 1: one request every 3 cycles, 2: random),
    // feeding FIFO data exactly one cycle after each payload request.
    task automatic sendBytes(input int nBytes, input int gapMode);
        int i, pending, idle;
        bit issue, finished;
        i = 0; pending = -1; idle = 0; finished = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            @(negedge video_rd_clk);
            if (pending >= 4) video_rd_data = expStream[pending];
            else              video_rd_data = 8'($urandom);
            issue = (i < nBytes) && (idle == 0);
            tx_req = issue;
            #1;
            if (pending >= 0)
                checkOutput($sformatf("txData[%0d]", pending), 32'(tx_data), 32'(expStream[pending]));
            checkOutput("rdEnComb", 32'(video_rd_en), 32'(issue && (i >= 4)));
            if (issue) begin
                pending = i;
                i++;
                idle = (gapMode == 0) ? 0 : (gapMode == 1) ? 2 : int'($urandom_range(0, 2));
            end else begin
                pending = -1;
                if (idle > 0) idle--;
            end
            if (i >= nBytes && pending < 0) finished = 1'b1;
        end
        tx_req = 1'b0;
        checkOutput("sendFinished", 32'(finished), 32'd1);
    endtask

    // One full packet: start, header + payload, optional stray tx_req in
    // WAIT_DONE, then tx_done and a check of the new numbering.
    task automatic applyStimulus(input int gapMode, input bit overrun, input bit alreadyStarted);
        int s0, r0;
        s0 = startCount;
        r0 = rdEnCount;
        ctrl_en = 1'b1;
        video_rd_rdy = 1'b1;
        if (!alreadyStarted) waitStart();
        ctrl_en = 1'($urandom);
        video_rd_rdy = 1'($urandom);
        buildStream();
        sendBytes(NBYTES, gapMode);
        checkOutput("rdEnPulses", 32'(rdEnCount - r0), 32'(PAY));
        checkOutput("startPulses", 32'(startCount - s0), 32'd1);
        checkOutput("byteNumWait", 32'(tx_byte_num), 32'(NBYTES));
        if (overrun) begin
            @(negedge video_rd_clk);
            tx_req = 1'b1;
            #1;
            checkOutput("rdEnOverrun", 32'(video_rd_en), 32'd0);
            @(negedge video_rd_clk);
            tx_req = 1'b0;
            #1;
            checkOutput("errSet", 32'(err_overrun), 32'd1);
            checkOutput("rdEnPulsesOvr", 32'(rdEnCount - r0), 32'(PAY));
        end
        @(negedge video_rd_clk);
        tx_done = 1'b1;
        @(negedge video_rd_clk);
        tx_done = 1'b0;
        ctrl_en = 1'b0;
        modelDone();
        #1;
        checkOutput("pktCnt", 32'(pkt_cnt), 32'(expPkt));
        checkOutput("frameCnt", 32'(frame_cnt), 32'(expFrame));
    endtask

    initial begin
        int s0, r0;
        Reset = 1'b0; ctrl_en = 1'b0; video_rd_rdy = 1'b0;
        video_rd_data = 8'd0; tx_req = 1'b0; tx_done = 1'b0;
        #2 Reset = 1'b1;
        repeat (3) @(negedge video_rd_clk);
        #1;
        checkOutput("rstRdEn", 32'(video_rd_en), 32'd0);
        checkOutput("rstStart", 32'(tx_start_en), 32'd0);
        checkOutput("rstByteNum", 32'(tx_byte_num), 32'd0);
        checkOutput("rstTxData", 32'(tx_data), 32'd0);
        checkOutput("rstFrame", 32'(frame_cnt), 32'd0);
        checkOutput("rstPkt", 32'(pkt_cnt), 32'd0);
        checkOutput("rstErr", 32'(err_overrun), 32'd0);
        @(negedge video_rd_clk);
        Reset = 1'b0;

        // Three packets close a frame; the fourth carries frame 1, packet 0.
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);
        for (int p = 0; p < 5; p++) applyStimulus(2, 1'b0, 1'b0);
        checkOutput("noErr", 32'(err_overrun), 32'd0);

        // tx_done while idle must not move the counters.
        @(negedge video_rd_clk);
        tx_done = 1'b1;
        @(negedge video_rd_clk);
        tx_done = 1'b0;
        #1;
        checkOutput("idleDonePkt", 32'(pkt_cnt), 32'(expPkt));
        checkOutput("idleDoneFrame", 32'(frame_cnt), 32'(expFrame));

        applyStimulus(2, 1'b1, 1'b0);

        // Not ready: no start for 100 cycles, then start right after rdy.
        s0 = startCount;
        ctrl_en = 1'b1;
        video_rd_rdy = 1'b0;
        repeat (100) @(negedge video_rd_clk);
        checkOutput("noStartNotRdy", 32'(startCount - s0), 32'd0);
        video_rd_rdy = 1'b1;
        @(negedge video_rd_clk);
        #1;
        checkOutput("startAfterRdy", 32'(tx_start_en), 32'd1);
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("errHeld", 32'(err_overrun), 32'd1);

        // Reset after the third payload byte abandons the packet.
        ctrl_en = 1'b1;
        video_rd_rdy = 1'b1;
        waitStart();
        buildStream();
        sendBytes(7, 0);
        @(negedge video_rd_clk);
        tx_req = 1'b1;
        #2 Reset = 1'b1;
        #1;
        checkOutput("midRstRdEn", 32'(video_rd_en), 32'd0);
        checkOutput("midRstStart", 32'(tx_start_en), 32'd0);
        checkOutput("midRstByteNum", 32'(tx_byte_num), 32'd0);
        checkOutput("midRstTxData", 32'(tx_data), 32'd0);
        checkOutput("midRstFrame", 32'(frame_cnt), 32'd0);
        checkOutput("midRstPkt", 32'(pkt_cnt), 32'd0);
        checkOutput("midRstErr", 32'(err_overrun), 32'd0);
        tx_req = 1'b0;
        ctrl_en = 1'b0;
        @(negedge video_rd_clk);
        Reset = 1'b0;
        expFrame = 0;
        expPkt = 0;
        s0 = startCount;
        r0 = rdEnCount;
        repeat (5) @(negedge video_rd_clk);
        checkOutput("postRstStart", 32'(startCount - s0), 32'd0);
        checkOutput("postRstRdEn", 32'(rdEnCount - r0), 32'd0);
        applyStimulus(0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
